// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter: data width, default bit
// timing and the frame state encoding.
package uart_pkg;

    localparam int DATA_W           = 8;
    localparam int BIT_IDX_W        = 3;
    localparam int CLKS_PER_BIT_DEF = 868;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    function automatic logic is_last_bit(input logic [BIT_IDX_W-1:0] idx);
        return (idx == 3'd7);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a requester (master) and the UART transmitter (slave).
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/uart_tx_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count
// with a one-cycle tick; held at zero while clear_in is high.
module baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk_in,
    input  logic resetn_in,
    input  logic clear_in,
    output logic tick_out
);

    localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    // Next count: clear, wrap at terminal count, or increment.
    always_comb begin
        w_count_nxt = r_count;
        if (clear_in) begin
            w_count_nxt = {CNT_W{1'b0}};
        end else if (r_count == TERM) begin
            w_count_nxt = {CNT_W{1'b0}};
        end else begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign tick_out = (r_count == TERM) && !clear_in;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte over a valid/ready handshake and
// shifts it out LSB first with start and stop bits on a registered line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic     clk_in,
    input  logic     resetn_in,
    uart_tx_if.slave bus,
    output logic     tx_out,
    output logic     busy_out,
    output logic     done_out
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_W-1:0]     r_shift;
    logic [DATA_W-1:0]     w_shift_nxt;
    logic [BIT_IDX_W-1:0]  r_bit_idx;
    logic [BIT_IDX_W-1:0]  w_bit_idx_nxt;
    logic                  r_tx;
    logic                  w_tx_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  w_tick;
    logic                  w_ready;
    logic                  w_accept;

    assign w_ready  = (r_state == IDLE);
    assign w_accept = w_ready && bus.valid_in;

    // The timer idles at zero, so the start bit's first period begins on the accepting edge.
    baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_in    (clk_in),
        .resetn_in (resetn_in),
        .clear_in  (w_ready),
        .tick_out  (w_tick)
    );

    // Next-state and next-output decode of the frame sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_tx_nxt      = r_tx;
        w_done_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = START;
                    w_shift_nxt   = bus.data_in;
                    w_bit_idx_nxt = 3'd0;
                    w_tx_nxt      = 1'b0;
                end else begin
                    w_tx_nxt      = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
                end else begin
                    w_state_nxt = START;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (is_last_bit(r_bit_idx)) begin
                        w_state_nxt   = STOP;
                        w_tx_nxt      = 1'b1;
                        w_bit_idx_nxt = 3'd0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = r_shift[0];
                        w_shift_nxt   = {1'b0, r_shift[DATA_W-1:1]};
                    end
                end else begin
                    w_state_nxt = DATA;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = STOP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // Sequencer state, shift register and registered line/done outputs.
    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            r_state   <= IDLE;
            r_shift   <= 8'd0;
            r_bit_idx <= 3'd0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_tx      <= w_tx_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign bus.ready_out = w_ready;
    assign busy_out      = ~w_ready;
    assign tx_out        = r_tx;
    assign done_out      = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: directed bytes push hand-computed frames,
// per-DUT monitors check every line cycle, the done pulse and frame gaps.
module tb_uart_tx;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    logic tx4, busy4, done4;
    logic tx868, busy868, done868;

    uart_tx_if if4 ();
    uart_tx_if if868 ();

    uart_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk_in    (clk),
        .resetn_in (resetn),
        .bus       (if4),
        .tx_out    (tx4),
        .busy_out  (busy4),
        .done_out  (done4)
    );

    uart_tx #(.CLKS_PER_BIT(868)) dut868 (
        .clk_in    (clk),
        .resetn_in (resetn),
        .bus       (if868),
        .tx_out    (tx868),
        .busy_out  (busy868),
        .done_out  (done868)
    );

    always #5 clk = ~clk;

    // frame bit i is the i-th bit on the line: start, d0..d7, stop
    typedef struct {
        logic [9:0] frame;
        int         ncyc;
        bit         b2b;
    } exp_t;

    exp_t q4[$];
    exp_t q868[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endfunction

    task automatic push(input int sel, input logic [9:0] frame, input int ncyc, input bit b2b);
        exp_t e;
        e.frame = frame;
        e.ncyc  = ncyc;
        e.b2b   = b2b;
        if (sel == 0) q4.push_back(e);
        else          q868.push_back(e);
    endtask

    task automatic send(input int sel, input logic [7:0] d, input logic [9:0] frame,
                        input int ncyc, input bit b2b);
        int   n = 0;
        logic rdy;
        @(negedge clk);
        if (sel == 0) begin
            if4.data_in = d;   if4.valid_in = 1'b1;
        end else begin
            if868.data_in = d; if868.valid_in = 1'b1;
        end
        rdy = (sel == 0) ? if4.ready_out : if868.ready_out;
        while (!rdy && n < 20000) begin
            @(negedge clk);
            n++;
            rdy = (sel == 0) ? if4.ready_out : if868.ready_out;
        end
        if (!rdy) chk($sformatf("accept_timeout_dut%0d", sel), 32'd0, 32'd1);
        else      push(sel, frame, ncyc, b2b);
        @(posedge clk);
    endtask

    task automatic wait_idle(input int sel, input int limit);
        int   n = 0;
        logic rdy;
        @(negedge clk);
        rdy = (sel == 0) ? if4.ready_out : if868.ready_out;
        while (!rdy && n < limit) begin
            @(negedge clk);
            n++;
            rdy = (sel == 0) ? if4.ready_out : if868.ready_out;
        end
        if (!rdy) chk($sformatf("idle_timeout_dut%0d", sel), 32'd0, 32'd1);
    endtask

    task automatic mon(input int sel, input int clks);
        exp_t e;
        logic t, d, r, exp_bit, bad_val, bit_bad, done_seen;
        int   since_done = 1000;
        int   qs, lim;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                since_done = 1000;
            end else begin
                t = (sel == 0) ? tx4 : tx868;
                d = (sel == 0) ? done4 : done868;
                if (since_done < 1000) since_done++;
                if (since_done == 1) chk($sformatf("done_width_dut%0d", sel), d, 1'b0);
                if (t == 1'b0) begin
                    qs = (sel == 0) ? q4.size() : q868.size();
                    if (qs == 0) begin
                        chk($sformatf("unexpected_start_dut%0d", sel), 32'd1, 32'd0);
                        lim = 0;
                        while (t == 1'b0 && lim < 20000) begin
                            @(negedge clk);
                            lim++;
                            t = (sel == 0) ? tx4 : tx868;
                        end
                    end else begin
                        e = (sel == 0) ? q4.pop_front() : q868.pop_front();
                        if (e.b2b) chk($sformatf("b2b_gap_dut%0d", sel), since_done, 32'd1);
                        done_seen = 1'b0;
                        bit_bad   = 1'b0;
                        bad_val   = 1'b0;
                        for (int k = 0; k < e.ncyc; k++) begin
                            if (k > 0) begin
                                @(negedge clk);
                                t = (sel == 0) ? tx4 : tx868;
                                d = (sel == 0) ? done4 : done868;
                            end
                            exp_bit = e.frame[k / clks];
                            if (t !== exp_bit) begin
                                bit_bad = 1'b1;
                                bad_val = t;
                            end
                            if (d !== 1'b0) done_seen = 1'b1;
                            if ((k % clks) == (clks - 1)) begin
                                chk($sformatf("line_bit%0d_dut%0d", k / clks, sel),
                                    bit_bad ? bad_val : exp_bit, exp_bit);
                                bit_bad = 1'b0;
                            end
                        end
                        chk($sformatf("done_in_frame_dut%0d", sel), done_seen, 1'b0);
                        if (e.ncyc == 10 * clks) begin
                            @(negedge clk);
                            t = (sel == 0) ? tx4 : tx868;
                            d = (sel == 0) ? done4 : done868;
                            r = (sel == 0) ? if4.ready_out : if868.ready_out;
                            chk($sformatf("done_pulse_dut%0d", sel), d, 1'b1);
                            chk($sformatf("idle_line_dut%0d", sel), t, 1'b1);
                            chk($sformatf("ready_after_dut%0d", sel), r, 1'b1);
                            since_done = 0;
                        end else begin
                            lim = 0;
                            while (resetn && lim < 200) begin
                                @(negedge clk);
                                lim++;
                            end
                            chk($sformatf("abort_reset_dut%0d", sel), resetn, 1'b0);
                            since_done = 1000;
                        end
                    end
                end
            end
        end
    endtask

    initial mon(0, 4);
    initial mon(1, 868);

    initial begin
        resetn         = 1'b0;
        if4.data_in    = 8'hA5;
        if4.valid_in   = 1'b1;
        if868.data_in  = 8'h00;
        if868.valid_in = 1'b0;

        // reset held with a pending request: no frame may start
        repeat (5) @(negedge clk);
        chk("rst_tx",    tx4,           1'b1);
        chk("rst_ready", if4.ready_out, 1'b1);
        chk("rst_busy",  busy4,         1'b0);
        chk("rst_done",  done4,         1'b0);
        chk("rst_tx868", tx868,         1'b1);

        // first edge after release accepts 0xA5; start bit one cycle later
        resetn = 1'b1;
        push(0, 10'b1101001010, 40, 1'b0);
        @(posedge clk);
        #1;
        chk("start_latency", tx4,   1'b0);
        chk("busy_in_frame", busy4, 1'b1);
        if4.valid_in = 1'b0;
        wait_idle(0, 200);

        // back-to-back 0x00 then 0xFF with valid held; data changes mid-frame
        send(0, 8'h00, 10'b1000000000, 40, 1'b0);
        send(0, 8'hFF, 10'b1111111110, 40, 1'b1);
        @(negedge clk);
        if4.data_in = 8'h5A;
        repeat (10) @(negedge clk);
        if4.valid_in = 1'b0;
        wait_idle(0, 200);

        // 0xF0 aborted by reset during data bit 3 (a low bit)
        send(0, 8'hF0, 10'b1111100000, 16, 1'b0);
        #1 if4.valid_in = 1'b0;
        repeat (18) @(posedge clk);
        #2;
        chk("pre_abort_tx", tx4, 1'b0);
        #1 resetn = 1'b0;
        #1;
        chk("abort_tx_high", tx4,           1'b1);
        chk("abort_ready",   if4.ready_out, 1'b1);
        chk("abort_busy",    busy4,         1'b0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("no_resume_%0d", i), tx4, 1'b1);
        end
        send(0, 8'h3C, 10'b1001111000, 40, 1'b0);
        #1 if4.valid_in = 1'b0;
        wait_idle(0, 200);

        // full-rate timing: 0x55 at 868 clocks per bit
        send(1, 8'h55, 10'b1010101010, 8680, 1'b0);
        #1 if868.valid_in = 1'b0;
        wait_idle(1, 9000);

        repeat (3) @(negedge clk);
        chk("q4_drained",   q4.size(),   32'd0);
        chk("q868_drained", q868.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk_in cycles per serial bit (100 MHz / 115200 baud); legal range >= 2.
REQ-002 clk_in  input  1  single system clock; all state updates on rising edge.
REQ-003 resetn_in  input  1  reset, asynchronous, active-low.
REQ-004 data_in  input  8  byte to transmit; sampled only on an accepting edge.
REQ-005 valid_in  input  1  requester has a byte on data_in.
REQ-006 ready_out  output  1  block can accept a byte this cycle.
REQ-007 tx_out  output  1  serial line; idle high.
REQ-008 busy_out  output  1  frame in progress.
REQ-009 done_out  output  1  one-cycle pulse when a frame's stop bit completes.

Function
REQ-010 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); no parity.
REQ-011 Each bit SHALL be driven on tx_out for exactly CLKS_PER_BIT cycles; a full frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-012 Accept SHALL occur on a rising edge where valid_in=1 and ready_out=1; data_in SHALL be latched into an internal shift register on that edge.
REQ-013 tx_out SHALL go low (start bit) in the cycle immediately after the accepting edge (latency 1 cycle).
REQ-014 ready_out SHALL be 1 only in state IDLE and SHALL be a registered/state-decoded output, not combinationally dependent on valid_in.
REQ-015 busy_out SHALL equal NOT ready_out.
REQ-016 State machine states: IDLE, START, DATA, STOP.
REQ-017 IDLE -> START on accept; START -> DATA after CLKS_PER_BIT cycles; DATA -> STOP after 8 bit periods; STOP -> IDLE after CLKS_PER_BIT cycles.
REQ-018 Bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary; bit index counter SHALL be 3 bits, 0..7.
REQ-019 done_out SHALL pulse high for exactly one cycle, the cycle the STOP->IDLE transition occurs.
REQ-020 Back-to-back: if valid_in is held high, the next accept SHALL occur on the first edge in IDLE, so consecutive frames are separated by exactly one idle-high cycle.
REQ-021 Changes on data_in or valid_in while busy_out=1 SHALL have no effect on the frame in progress.
REQ-022 tx_out SHALL be driven from a flip-flop (glitch-free).

Reset
REQ-023 While resetn_in=0: state=IDLE, tx_out=1, ready_out=1, busy_out=0, done_out=0, all counters and shift register=0.
REQ-024 Reset assertion mid-frame SHALL immediately abort the frame and force tx_out high; no partial-frame resumption after release.
REQ-025 First accept after reset release SHALL be possible on the first rising edge with resetn_in=1.

Structure
REQ-026 Shared package uart_pkg SHALL hold the state encoding constants, the 8-bit data width, and the default CLKS_PER_BIT.
REQ-027 Bit-period timing SHALL be a sub-module baud_counter (clk_in, resetn_in, clear input, one-cycle tick output at terminal count).
REQ-028 Implementation SHALL be 120-400 lines of synthesizable RTL, no latches, no generated clocks.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-029 Reset: hold resetn_in=0 with valid_in=1 -> tx_out=1, ready_out=1, busy_out=0, no frame started.
REQ-030 Single byte 0xA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done_out one pulse 40 cycles after the start bit begins.
REQ-031 Back-to-back 0x00 then 0xFF with valid_in held -> second start bit exactly 1 cycle after first stop bit ends; data_in change mid-frame ignored.
REQ-032 Reset asserted in DATA bit 3 -> tx_out high asynchronously; after release, send 0x3C -> correct complete frame.
REQ-033 CLKS_PER_BIT=868, byte 0x55 -> each bit exactly 868 cycles, frame 8680 cycles.
